// File: rtl/range_check_scheduler.sv
// Shared range comparator: round-robin arbitration over N_CH sample streams, a
// 2-stage signed bound check, and sticky violation status with optional halt.
module range_check_scheduler #(
  parameter int N_CH         = 4,
  parameter int WIDTH        = 16,
  parameter int EXPONENT     = -8,
  parameter int CNT_W        = 8,
  parameter int HALT_ON_FAIL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*WIDTH-1:0]     in_data,
  input  logic [N_CH-1:0]           in_valid,
  output logic [N_CH-1:0]           in_ready,
  input  logic [N_CH*WIDTH-1:0]     lim,
  input  logic                      clear,
  output logic [N_CH-1:0]           viol_flags,
  output logic                      first_valid,
  output logic [$clog2(N_CH)-1:0]   first_ch,
  output logic [WIDTH-1:0]          first_val,
  output logic [CNT_W-1:0]          viol_count,
  output logic                      halted,
  output logic                      busy
);
  // EXPONENT only names the fixed-point scale; it cancels out of the channel index width.
  localparam int CH_W = $clog2(N_CH) + (EXPONENT - EXPONENT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_CH-1:0][WIDTH-1:0] data_a, lim_a;
  assign data_a = in_data;
  assign lim_a  = lim;

  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CH_W:0]    idx;
  logic [CH_W-1:0]  gnt;
  logic             gnt_vld, hs;

  logic [1:0]       vld_pipe_q, vld_pipe_d;
  logic [CH_W-1:0]  s1_ch_q, s1_ch_d, s2_ch_q, s2_ch_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d, s1_lim_q, s1_lim_d, s2_data_q, s2_data_d;
  logic             s2_fail_q, s2_fail_d;

  logic [N_CH-1:0]  flags_q, flags_d;
  logic             fv_q, fv_d;
  logic [CH_W-1:0]  fch_q, fch_d;
  logic [WIDTH-1:0] fval_q, fval_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  logic signed [WIDTH:0] smp_x, lim_x, nlim_x;
  logic             fail, commit;

  // first valid channel at or after the round-robin pointer, with wrap
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_q} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
      if (!gnt_vld && in_valid[idx[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[CH_W-1:0];
      end
    end
  end

  assign hs = gnt_vld && !rst && !halted_q;

  always_comb begin
    in_ready = '0;
    if (hs) in_ready[gnt] = 1'b1;
  end

  // one extra bit keeps -lim exact for the full unsigned bound range
  always_comb begin
    smp_x  = {s1_data_q[WIDTH-1], s1_data_q};
    lim_x  = {1'b0, s1_lim_q};
    nlim_x = -lim_x;
    fail   = !s1_lim_q[WIDTH-1] && ((smp_x > lim_x) || (smp_x < nlim_x));
  end

  assign commit = vld_pipe_q[1] && s2_fail_q;

  always_comb begin
    rr_d       = rr_q;
    if (hs) rr_d = (gnt == CH_W'(N_CH-1)) ? '0 : gnt + CH_W'(1);

    vld_pipe_d = {vld_pipe_q[0], hs};
    s1_ch_d    = hs ? gnt         : s1_ch_q;
    s1_data_d  = hs ? data_a[gnt] : s1_data_q;
    s1_lim_d   = hs ? lim_a[gnt]  : s1_lim_q;
    s2_ch_d    = vld_pipe_q[0] ? s1_ch_q   : s2_ch_q;
    s2_data_d  = vld_pipe_q[0] ? s1_data_q : s2_data_q;
    s2_fail_d  = vld_pipe_q[0] ? fail      : s2_fail_q;

    // clear first, then a same-cycle commit lands on the cleared state
    flags_d  = clear ? '0   : flags_q;
    cnt_d    = clear ? '0   : cnt_q;
    fv_d     = clear ? 1'b0 : fv_q;
    halted_d = clear ? 1'b0 : halted_q;
    fch_d    = fch_q;
    fval_d   = fval_q;
    if (commit) begin
      flags_d[s2_ch_q] = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
      if (!fv_d) begin
        fv_d   = 1'b1;
        fch_d  = s2_ch_q;
        fval_d = s2_data_q;
      end
      if (HALT_ON_FAIL != 0) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      vld_pipe_q <= '0;
      s1_ch_q    <= '0;
      s1_data_q  <= '0;
      s1_lim_q   <= '0;
      s2_ch_q    <= '0;
      s2_data_q  <= '0;
      s2_fail_q  <= 1'b0;
      flags_q    <= '0;
      fv_q       <= 1'b0;
      fch_q      <= '0;
      fval_q     <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      vld_pipe_q <= vld_pipe_d;
      s1_ch_q    <= s1_ch_d;
      s1_data_q  <= s1_data_d;
      s1_lim_q   <= s1_lim_d;
      s2_ch_q    <= s2_ch_d;
      s2_data_q  <= s2_data_d;
      s2_fail_q  <= s2_fail_d;
      flags_q    <= flags_d;
      fv_q       <= fv_d;
      fch_q      <= fch_d;
      fval_q     <= fval_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
    end
  end

  assign viol_flags  = flags_q;
  assign first_valid = fv_q;
  assign first_ch    = fch_q;
  assign first_val   = fval_q;
  assign viol_count  = cnt_q;
  assign halted      = halted_q;
  assign busy        = |vld_pipe_q;
endmodule
